led_control: RTL and testbench



---
 rtl/led_control_if.sv | 38 +++
 rtl/led_control.sv | 63 ++++++
 tb/tb_led_control.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/led_control_if.sv
// led_control_if
//   Groups the signals between the WS2812B control state machine and its
//   neighbours: the go requester and the datapath blocks (return timer,
//   bit-waveform generator and frame shift register).
//
//   Signals:
//     go           request to start transmitting a frame
//     retDone      return/latch low period has elapsed (from return timer)
//     sendDone     all frame bits transmitted (from bit counter/shift register)
//     registerBit  current MSB of the frame shift register
//     doGen        enable the bit-waveform generator
//     doRet        enable the return timer; line held low
//     loadRegister shift register parallel-loads a new frame
//     genMode      waveform code: 00 none, 10 '0' code, 11 '1' code
//
//   Modports:
//     master  the environment side (drives requests/status, observes controls)
//     slave   the control state machine side
interface led_control_if;
  logic       go;
  logic       retDone;
  logic       sendDone;
  logic       registerBit;
  logic       doGen;
  logic       doRet;
  logic       loadRegister;
  logic [1:0] genMode;

  modport master (
    output go, retDone, sendDone, registerBit,
    input  doGen, doRet, loadRegister, genMode
  );

  modport slave (
    input  go, retDone, sendDone, registerBit,
    output doGen, doRet, loadRegister, genMode
  );
endinterface

// File: rtl/led_control.sv
// led_control
//   Control state machine for the WS2812B serial LED driver. Alternates
//   between a return/latch phase (RET) and a bit transmission phase (SEND).
//   In RET the return timer runs and the shift register loads the next frame;
//   in SEND the waveform generator emits the code for the current frame bit.
//
//   Ports:
//     clk    system clock, all state changes on the rising edge
//     reset  synchronous, active-high; forces RET on the next rising edge
//     bus    led_control_if.slave -- go/retDone/sendDone/registerBit in,
//            doGen/doRet/loadRegister/genMode out
module led_control (
  led_control_if.slave bus,
  input  logic         clk,
  input  logic         reset
);

  typedef enum logic {
    RET  = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t stateReg;
  state_t stateNext;

  logic doGenNext;
  logic doRetNext;
  logic loadRegisterNext;

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg <= RET;
    end else begin
      stateReg <= stateNext;
    end
  end

  // Next-state and Moore output decode. Any encoding other than SEND
  // (including an unknown value) falls into the RET branch.
  always_comb begin
    stateNext        = RET;
    doGenNext        = 1'b0;
    doRetNext        = 1'b1;
    loadRegisterNext = 1'b1;
    if (stateReg == SEND) begin
      doGenNext        = 1'b1;
      doRetNext        = 1'b0;
      loadRegisterNext = 1'b0;
      // sendDone always wins; go/retDone are ignored while sending
      stateNext        = bus.sendDone ? RET : SEND;
    end else begin
      // The latch period must complete before a new frame may start
      stateNext        = (bus.go && bus.retDone) ? SEND : RET;
    end
  end

  assign bus.doGen        = doGenNext;
  assign bus.doRet        = doRetNext;
  assign bus.loadRegister = loadRegisterNext;
  // genMode[0] follows registerBit combinationally while sending
  assign bus.genMode      = {doGenNext, doGenNext & bus.registerBit};

endmodule

// File: tb/tb_led_control.sv
module tb_led_control;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  led_control_if bus ();

  led_control dut (
    .bus   (bus.slave),
    .clk   (clk),
    .reset (reset)
  );

  always #5 clk = ~clk;

  // Reference: is a frame currently being transmitted?
  bit frameActive = 1'b0;
  bit modelValid  = 1'b0;

  always @(posedge clk) begin
    modelValid <= 1'b1;
    if (reset)
      frameActive <= 1'b0;
    else if (frameActive)
      frameActive <= !bus.sendDone;
    else
      frameActive <= bus.go && bus.retDone;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs as {doGen, doRet, loadRegister, genMode}
  function automatic logic [4:0] expected(bit active, logic rb);
    if (active) return {1'b1, 1'b0, 1'b0, 1'b1, rb};
    return 5'b01100;
  endfunction

  function automatic logic [4:0] actual();
    return {bus.doGen, bus.doRet, bus.loadRegister, bus.genMode};
  endfunction

  // Continuous compare against the model, away from the active edge
  always @(negedge clk) begin
    if (modelValid)
      check("model", {27'b0, actual()}, {27'b0, expected(frameActive, bus.registerBit)});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOut(input string name, input logic [4:0] exp);
    check(name, {27'b0, actual()}, {27'b0, exp});
  endtask

  initial begin
    reset           = 1'b1;
    bus.go          = 1'b0;
    bus.retDone     = 1'b0;
    bus.sendDone    = 1'b0;
    bus.registerBit = 1'b0;

    // Reset hold
    step();
    checkOut("reset_ret", 5'b01100);
    reset       = 1'b0;
    bus.retDone = 1'b1;
    repeat (2) begin
      step();
      checkOut("idle_ret", 5'b01100);
    end

    // Start
    bus.go = 1'b1;
    step();
    checkOut("start_send", 5'b10010);
    bus.go      = 1'b0;
    bus.retDone = 1'b0;

    // Bit follow (combinational, no edge in between)
    #1 bus.registerBit = 1'b1;
    #1 checkOut("follow_11", 5'b10011);
    bus.registerBit = 1'b0;
    #1 checkOut("follow_10", 5'b10010);
    step();
    checkOut("still_send", 5'b10010);

    // Finish with go/retDone held -> re-enter one edge later
    bus.sendDone = 1'b1;
    bus.go       = 1'b1;
    bus.retDone  = 1'b1;
    step();
    checkOut("finish_ret", 5'b01100);
    bus.sendDone = 1'b0;
    step();
    checkOut("restream", 5'b10010);

    // Gating: go without retDone stays in RET
    bus.sendDone = 1'b1;
    bus.go       = 1'b0;
    step();
    checkOut("back_ret", 5'b01100);
    bus.sendDone = 1'b0;
    bus.go       = 1'b1;
    bus.retDone  = 1'b0;
    repeat (3) begin
      step();
      checkOut("gated", 5'b01100);
    end
    bus.retDone = 1'b1;
    step();
    checkOut("ungated", 5'b10010);

    // Reset mid-send
    bus.registerBit = 1'b1;
    #1 checkOut("pre_reset", 5'b10011);
    reset = 1'b1;
    step();
    checkOut("reset_mid", 5'b01100);
    reset = 1'b0;

    // Randomized traffic, checked every cycle by the compare process
    for (int i = 0; i < 3000; i++) begin
      reset           = ($urandom_range(0, 99) < 2);
      bus.go          = ($urandom_range(0, 99) < 60);
      bus.retDone     = ($urandom_range(0, 99) < 50);
      bus.sendDone    = ($urandom_range(0, 99) < 15);
      bus.registerBit = $urandom_range(0, 1);
      step();
      // mid-cycle registerBit change must show before the negedge compare
      if ($urandom_range(0, 3) == 0) begin
        #1 bus.registerBit = ~bus.registerBit;
      end
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
